instruction_fetch_multi: RTL

//  Parametrised successor of the single-byte instruction fetcher. Takes a PC from
//  the previous pipeline stage via DIR/ack_prev and issues INSN_WORDS sequential

---
 rtl/instruction_fetch_multi_pkg.sv | 15 +
 rtl/instruction_fetch_multi.sv | 101 ++++++++++
 2 files changed

// File: rtl/instruction_fetch_multi_pkg.sv
// Shared definitions for the multi-word instruction fetcher.
// Holds the FSM state encoding and the handshake polarity constants.
package instruction_fetch_multi_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_GAP  = 2'd2,
      S_HOLD = 2'd3
   } fetch_state_t;

   localparam logic HS_ASSERT   = 1'b1;
   localparam logic HS_DEASSERT = 1'b0;

endpackage

// File: rtl/instruction_fetch_multi.sv
// Multi-word instruction fetcher: takes a PC, reads INSN_WORDS sequential memory
// words and presents the assembled instruction with its PC to the decode stage.
module instruction_fetch_multi
   import instruction_fetch_multi_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int INSN_WORDS = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         DIR,
   output logic                         ack_prev,
   input  logic [ADDR_W-1:0]            data_in,
   output logic                         DOR,
   input  logic                         ack_from_next,
   output logic [INSN_WORDS*DATA_W-1:0] data_out,
   output logic [ADDR_W-1:0]            pc_out,
   input  logic                         flush,
   output logic                         mem_en,
   output logic [ADDR_W-1:0]            mem_addr,
   output logic [DATA_W-1:0]            mem_di,
   input  logic [DATA_W-1:0]            mem_do,
   input  logic                         mem_do_ack
);

   localparam int                CNT_W     = $clog2(INSN_WORDS) + 1;
   localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(INSN_WORDS - 1);

   fetch_state_t     state;
   logic [CNT_W-1:0] cnt;

   // The memory port is read-only from this stage.
   assign mem_di = '0;

   // NOTE: all state and outputs are updated with non-blocking assignments so every
   // branch below sees the values from before this edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         ack_prev <= HS_DEASSERT;
         DOR      <= HS_DEASSERT;
         mem_en   <= 1'b0;
         mem_addr <= '0;
         pc_out   <= '0;
         data_out <= '0;
      end else begin
         ack_prev <= HS_DEASSERT;
         if (flush) begin
            // Redirect wins over everything; a partially assembled word is dropped.
            state  <= S_IDLE;
            cnt    <= '0;
            DOR    <= HS_DEASSERT;
            mem_en <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  DOR <= HS_DEASSERT;
                  if (DIR == HS_ASSERT) begin
                     pc_out   <= data_in;
                     mem_addr <= data_in;
                     cnt      <= '0;
                     ack_prev <= HS_ASSERT;
                     mem_en   <= 1'b1;
                     state    <= S_REQ;
                  end else begin
                     mem_en <= 1'b0;
                  end
               end
               S_REQ: begin
                  if (mem_do_ack) begin
                     data_out[cnt*DATA_W +: DATA_W] <= mem_do;
                     mem_en <= 1'b0;
                     if (cnt == LAST_WORD) begin
                        DOR   <= HS_ASSERT;
                        state <= S_HOLD;
                     end else begin
                        cnt      <= cnt + 1'b1;
                        mem_addr <= mem_addr + 1'b1;
                        state    <= S_GAP;
                     end
                  end
               end
               S_GAP: begin
                  mem_en <= 1'b1;
                  state  <= S_REQ;
               end
               S_HOLD: begin
                  if (ack_from_next == HS_ASSERT) begin
                     DOR   <= HS_DEASSERT;
                     state <= S_IDLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
